// File: rtl/isa_pkg.sv
// isa_pkg
//   Shared ISA definitions for the fetch stage and the control unit:
//   opcode and function-code constants, the canonical NOP encoding and
//   the fetch-stage next-state selection enum.
package isa_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h3;
  localparam logic [5:0] OP_J     = 6'h2;
  localparam logic [5:0] OP_JAL   = 6'h7;
  localparam logic [5:0] OP_BEQ   = 6'h4;
  localparam logic [5:0] OP_BNE   = 6'h5;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FUNC_JR  = 6'h8;

  // Encoding written into IF/ID when a bubble is inserted
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Which next-state case the fetch stage takes in a given cycle,
  // listed from highest to lowest priority.
  typedef enum logic [1:0] {
    ACT_REDIRECT = 2'd0,
    ACT_STALL    = 2'd1,
    ACT_JUMP     = 2'd2,
    ACT_SEQ      = 2'd3
  } fetch_act_e;

  // True for the jumps that are resolved early, in decode
  function automatic logic is_early_jump(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc
//   Combinational priority mux for the fetch stage. Picks between an EX
//   redirect, a stall, an early J/JAL taken from IF/ID and plain sequential
//   fetch, and reports what the registers in fetch_unit should do.
//
// Ports
//   pc             in   current PC register
//   if_id_valid    in   IF/ID holds a real instruction
//   if_id_instr    in   instruction held in IF/ID
//   if_id_pc4      in   PC+4 of the IF/ID instruction
//   stall          in   hold PC and IF/ID
//   redirect_valid in   EX redirect request
//   redirect_pc    in   EX redirect target
//   next_pc        out  value to load into the PC register
//   if_id_load     out  IF/ID register updates this cycle
//   if_id_bubble   out  the IF/ID update is a bubble rather than a fetch
//   fetch_inc      out  increment the fetch counter
//   bubble_inc     out  increment the bubble counter
module fetch_next_pc
  import isa_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              if_id_valid,
  input  logic [31:0]       if_id_instr,
  input  logic [ADDR_W-1:0] if_id_pc4,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic              if_id_load,
  output logic              if_id_bubble,
  output logic              fetch_inc,
  output logic              bubble_inc
);

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] jump_mask;
  logic [ADDR_W-1:0] jump_field;
  logic [ADDR_W-1:0] jump_target;
  logic              id_jump;
  fetch_act_e        act;

  assign pc_plus4 = pc + ADDR_W'(4);

  // Jump target keeps the upper PC+4 bits above bit 27 and replaces the
  // low 28 bits with the word index; the mask form works for any ADDR_W.
  assign jump_mask   = ADDR_W'(28'hFFF_FFFF);
  assign jump_field  = ADDR_W'({if_id_instr[25:0], 2'b00});
  assign jump_target = (if_id_pc4 & ~jump_mask) | (jump_field & jump_mask);

  assign id_jump = if_id_valid && is_early_jump(if_id_instr[31:26]);

  // Redirect beats stall beats early jump; a stalled jump stays in IF/ID
  // and is picked up on the first unstalled cycle.
  always_comb begin
    act = ACT_SEQ;
    if (redirect_valid) begin
      act = ACT_REDIRECT;
    end else if (stall) begin
      act = ACT_STALL;
    end else if (id_jump) begin
      act = ACT_JUMP;
    end
  end

  always_comb begin
    next_pc      = pc;
    if_id_load   = 1'b0;
    if_id_bubble = 1'b0;
    fetch_inc    = 1'b0;
    bubble_inc   = 1'b0;
    unique case (act)
      ACT_REDIRECT: begin
        next_pc      = redirect_pc;
        if_id_load   = 1'b1;
        if_id_bubble = 1'b1;
        bubble_inc   = 1'b1;
      end
      ACT_STALL: begin
        next_pc = pc;
      end
      ACT_JUMP: begin
        next_pc      = jump_target;
        if_id_load   = 1'b1;
        if_id_bubble = 1'b1;
        bubble_inc   = 1'b1;
      end
      ACT_SEQ: begin
        next_pc    = pc_plus4;
        if_id_load = 1'b1;
        fetch_inc  = 1'b1;
      end
      default: begin
        next_pc = pc;
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage plus IF/ID pipeline register. Holds the PC,
//   drives the instruction-memory address, captures the fetched word,
//   takes J/JAL early from IF/ID and applies EX redirects. Counts accepted
//   fetches and inserted bubbles.
//
// Ports
//   clk, rst       clock and synchronous active-high reset
//   imem_addr      out  current PC
//   imem_rdata     in   instruction at imem_addr (same-cycle read)
//   stall          in   hold PC and IF/ID
//   redirect_valid in   EX resolved a taken branch or jr
//   redirect_pc    in   target for the redirect
//   if_id_valid    out  IF/ID holds a real instruction
//   if_id_instr    out  IF/ID instruction (0 when invalid)
//   if_id_pc4      out  PC+4 of the IF/ID instruction (0 when invalid)
//   opcode, func   out  decode fields of if_id_instr
//   fetch_count    out  instructions accepted into IF/ID
//   bubble_count   out  cycles IF/ID was loaded with a bubble
module fetch_unit
  import isa_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000),
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_id_valid,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic [5:0]        opcode,
  output logic [5:0]        func,
  output logic [CNT_W-1:0]  fetch_count,
  output logic [CNT_W-1:0]  bubble_count
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic              if_id_load;
  logic              if_id_bubble;
  logic              fetch_inc;
  logic              bubble_inc;

  fetch_next_pc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .pc             (pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc4      (if_id_pc4),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .next_pc        (next_pc),
    .if_id_load     (if_id_load),
    .if_id_bubble   (if_id_bubble),
    .fetch_inc      (fetch_inc),
    .bubble_inc     (bubble_inc)
  );

  assign imem_addr = pc;
  assign opcode    = if_id_instr[31:26];
  assign func      = if_id_instr[5:0];

  // A fetch records PC+4 from the PC the word was read at, which is the
  // same value next_pc takes in the sequential case.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      if_id_valid  <= 1'b0;
      if_id_instr  <= NOP_INSTR;
      if_id_pc4    <= '0;
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      pc <= next_pc;
      if (if_id_load) begin
        if (if_id_bubble) begin
          if_id_valid <= 1'b0;
          if_id_instr <= NOP_INSTR;
          if_id_pc4   <= '0;
        end else begin
          if_id_valid <= 1'b1;
          if_id_instr <= imem_rdata;
          if_id_pc4   <= next_pc;
        end
      end
      if (fetch_inc) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end
      if (bubble_inc) begin
        bubble_count <= bubble_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Self-checking bench for fetch_unit. Every driven cycle pushes the
//   expected post-edge state onto a scoreboard queue; each test task pops
//   and compares it after the edge, plus directed constant checks.
module tb_fetch_unit;

  typedef struct packed {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] pc;
    logic [31:0] fc;
    logic [31:0] bc;
    logic [5:0]  op;
    logic [5:0]  fn;
  } snap_t;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;

  int n_checks = 0;
  int n_fail   = 0;

  snap_t exp_q[$];

  // Reference state of the fetch stage
  logic        m_v;
  logic [31:0] m_instr, m_pc4, m_pc, m_fc, m_bc;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc4      (if_id_pc4),
    .opcode         (opcode),
    .func           (func),
    .fetch_count    (fetch_count),
    .bubble_count   (bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t observe();
    snap_t s;
    s = '{v: if_id_valid, instr: if_id_instr, pc4: if_id_pc4, pc: imem_addr,
          fc: fetch_count, bc: bubble_count, op: opcode, fn: func};
    return s;
  endfunction

  // Drive one cycle, advance the reference model, queue the expectation,
  // then step past the rising edge.
  task automatic drive(input logic r, input logic st, input logic rv,
                       input logic [31:0] rpc, input logic [31:0] rdata);
    snap_t e;
    rst = r; stall = st; redirect_valid = rv; redirect_pc = rpc; imem_rdata = rdata;
    if (r) begin
      m_pc = 32'h0; m_v = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0; m_fc = 0; m_bc = 0;
    end else if (rv) begin
      m_pc = rpc; m_v = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0; m_bc = m_bc + 1;
    end else if (st) begin
      m_pc = m_pc;
    end else if (m_v && (m_instr[31:26] == 6'h2 || m_instr[31:26] == 6'h7)) begin
      m_pc = {m_pc4[31:28], m_instr[25:0], 2'b00};
      m_v = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0; m_bc = m_bc + 1;
    end else begin
      m_v = 1'b1; m_instr = rdata; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_fc = m_fc + 1;
    end
    e = '{v: m_v, instr: m_instr, pc4: m_pc4, pc: m_pc, fc: m_fc, bc: m_bc,
          op: m_instr[31:26], fn: m_instr[5:0]};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    snap_t e, g;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
      e = exp_q.pop_front(); g = observe(); n_checks++;
      if (g !== e) begin n_fail++; $display("[TB] FAIL reset_state got=%h exp=%h", g, e); end
    end
    n_checks++;
    if (imem_addr !== 32'h0 || if_id_valid !== 1'b0 || opcode !== 6'h0 || func !== 6'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_const addr=%h valid=%b op=%h fn=%h exp 0/0/0/0", imem_addr, if_id_valid, opcode, func);
    end
  endtask

  task automatic test_sequential();
    snap_t e, g;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, {6'h9, 26'h1});
      e = exp_q.pop_front(); g = observe(); n_checks++;
      if (g !== e) begin n_fail++; $display("[TB] FAIL seq_state[%0d] got=%h exp=%h", i, g, e); end
      n_checks++;
      if (if_id_pc4 !== 32'(4 * (i + 1)) || imem_addr !== 32'(4 * (i + 1))) begin
        n_fail++;
        $display("[TB] FAIL seq_pc4[%0d] pc4=%h addr=%h exp=%h", i, if_id_pc4, imem_addr, 4 * (i + 1));
      end
    end
    n_checks++;
    if (fetch_count !== 32'd3 || opcode !== 6'h9 || func !== 6'h1) begin
      n_fail++;
      $display("[TB] FAIL seq_count fc=%0d op=%h fn=%h exp 3/09/01", fetch_count, opcode, func);
    end
  endtask

  task automatic test_jump();
    snap_t e, g;
    logic [31:0] bc0;
    drive(1'b0, 1'b0, 1'b1, 32'h1000_000C, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, {6'h2, 26'h0000040});
    drive(1'b0, 1'b0, 1'b0, 32'h0, {6'h9, 26'h5});
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      if (i == 1) bc0 = e.bc;
      if (i == 2) begin
        g = observe(); n_checks++;
        if (g !== e) begin n_fail++; $display("[TB] FAIL jump_state got=%h exp=%h", g, e); end
      end
    end
    n_checks++;
    if (imem_addr !== 32'h1000_0100 || if_id_valid !== 1'b0 || bubble_count !== bc0 + 1) begin
      n_fail++;
      $display("[TB] FAIL jump_target addr=%h valid=%b bc=%0d exp 10000100/0/%0d", imem_addr, if_id_valid, bubble_count, bc0 + 1);
    end
  endtask

  task automatic test_redirect_stall();
    snap_t e, g;
    drive(1'b0, 1'b1, 1'b1, 32'h200, 32'h1234_5678);
    e = exp_q.pop_front(); g = observe(); n_checks++;
    if (g !== e) begin n_fail++; $display("[TB] FAIL redir_stall_state got=%h exp=%h", g, e); end
    n_checks++;
    if (imem_addr !== 32'h200 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL redir_wins addr=%h valid=%b instr=%h exp 200/0/0", imem_addr, if_id_valid, if_id_instr);
    end
  endtask

  task automatic test_stall_jal();
    snap_t e, g, held;
    drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h0);
    void'(exp_q.pop_front());
    drive(1'b0, 1'b0, 1'b0, 32'h0, {6'h7, 26'h100});
    void'(exp_q.pop_front());
    held = observe();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF);
      e = exp_q.pop_front(); g = observe(); n_checks++;
      if (g !== e || g !== held) begin
        n_fail++;
        $display("[TB] FAIL stall_hold[%0d] got=%h exp=%h", i, g, e);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    e = exp_q.pop_front(); g = observe(); n_checks++;
    if (g !== e || imem_addr !== 32'h400 || if_id_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stall_jal_taken got=%h exp=%h addr=%h", g, e, imem_addr);
    end
  endtask

  task automatic test_wrap();
    snap_t e, g;
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
    void'(exp_q.pop_front());
    drive(1'b0, 1'b0, 1'b0, 32'h0, {6'h9, 26'h2});
    e = exp_q.pop_front(); g = observe(); n_checks++;
    if (g !== e || imem_addr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pc_wrap got=%h exp=%h", g, e);
    end
  endtask

  task automatic test_back_to_back();
    snap_t e, g;
    logic [5:0] ops [4];
    ops[0] = 6'h2; ops[1] = 6'h7; ops[2] = 6'h4; ops[3] = 6'h9;
    for (int i = 0; i < 60; i++) begin
      drive(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            $urandom() & 32'hFFFF_FFFC, {ops[$urandom_range(0, 3)], 26'($urandom())});
      e = exp_q.pop_front(); g = observe(); n_checks++;
      if (g !== e) begin n_fail++; $display("[TB] FAIL random[%0d] got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_reset_midrun();
    snap_t e, g;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, {6'h9, 26'h3});
      void'(exp_q.pop_front());
    end
    drive(1'b1, 1'b1, 1'b1, 32'h800, 32'h0);
    e = exp_q.pop_front(); g = observe(); n_checks++;
    if (g !== e || imem_addr !== 32'h0 || if_id_valid !== 1'b0 || fetch_count !== 0 || bubble_count !== 0) begin
      n_fail++;
      $display("[TB] FAIL reset_midrun got=%h exp=%h", g, e);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_rdata = 32'h0;
    test_reset();
    test_sequential();
    test_jump();
    test_redirect_stall();
    test_stall_jal();
    test_wrap();
    test_back_to_back();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
